// File: rtl/pulse_gate_controller.sv
// Pulse gate controller: frames each above-threshold excursion of ADC channel A
// as one pulse, measures its width and peak, and emits a single event word on
// a valid/ready stream. A programmable holdoff follows every accepted event.
// Start edges seen while an event is pending or in holdoff are counted as drops.
module pulse_gate_controller #(
    parameter int unsigned ADC_WIDTH        = 14,
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned HYST             = 10,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                        adc_clk,
    input  logic                        rst,
    input  logic [AXIS_TDATA_WIDTH-1:0] adc_dat_a,
    input  logic [ADC_WIDTH-1:0]        input_low,
    input  logic                        enable,
    input  logic [CNT_WIDTH-1:0]        holdoff_len,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        gate,
    output logic                        busy,
    output logic [CNT_WIDTH-1:0]        drop_cnt
);

    // One extra bit so input_low + HYST never wraps.
    localparam int unsigned CmpW = ADC_WIDTH + 1;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StPulse,
        StEmit,
        StHoldoff
    } state_e;

    state_e state_q, state_d;

    logic signed [ADC_WIDTH-1:0] sample;
    logic signed [CmpW-1:0]      sample_ext;
    logic signed [CmpW-1:0]      low_ext;
    logic signed [CmpW-1:0]      high_ext;
    logic                        start_raw;
    logic                        end_raw;
    logic                        start_prev_q;
    logic                        handshake;
    logic                        drop_inc;

    logic [CNT_WIDTH-1:0]        width_q;
    logic signed [ADC_WIDTH-1:0] peak_q;
    logic [CNT_WIDTH-1:0]        holdoff_q;
    logic [31:0]                 event_word;

    assign sample     = adc_dat_a[ADC_WIDTH-1:0];
    assign sample_ext = {sample[ADC_WIDTH-1], sample};
    assign low_ext    = {input_low[ADC_WIDTH-1], input_low};
    assign high_ext   = low_ext + $signed(CmpW'(HYST));

    assign start_raw = sample_ext > high_ext;
    assign end_raw   = sample_ext < low_ext;

    // tvalid is high exactly while in StEmit, so the handshake follows the state.
    assign handshake = (state_q == StEmit) && m_axis_tready;
    assign drop_inc  = start_raw && !start_prev_q &&
                       ((state_q == StEmit) || (state_q == StHoldoff));

    // Event word: width in the upper half, peak sign-extended in the lower half.
    assign event_word = {width_q[15:0], {(16 - ADC_WIDTH){peak_q[ADC_WIDTH-1]}}, peak_q};

    // Next-state decode; enable loses to an outstanding event until it is accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StArmed;
            end
            StArmed: begin
                if (!enable)        state_d = StIdle;
                else if (start_raw) state_d = StPulse;
            end
            StPulse: begin
                if (!enable)      state_d = StIdle;
                else if (end_raw) state_d = StEmit;
            end
            StEmit: begin
                if (handshake) begin
                    if (holdoff_len != '0) state_d = StHoldoff;
                    else                   state_d = enable ? StArmed : StIdle;
                end
            end
            StHoldoff: begin
                if (holdoff_q <= CNT_WIDTH'(1)) state_d = enable ? StArmed : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, measurement datapath and registered outputs.
    always_ff @(posedge adc_clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            start_prev_q  <= 1'b0;
            width_q       <= '0;
            peak_q        <= '0;
            holdoff_q     <= '0;
            drop_cnt      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            gate          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_prev_q  <= start_raw;
            gate          <= (state_d == StPulse);
            busy          <= (state_d == StPulse) || (state_d == StEmit) ||
                             (state_d == StHoldoff);
            m_axis_tvalid <= (state_d == StEmit);

            if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);

            unique case (state_q)
                StArmed: begin
                    if (state_d == StPulse) begin
                        width_q <= CNT_WIDTH'(1);
                        peak_q  <= sample;
                    end
                end
                StPulse: begin
                    if (state_d == StEmit) begin
                        // End sample is excluded: latch what was measured so far.
                        m_axis_tdata <= AXIS_TDATA_WIDTH'(event_word);
                    end else if (state_d == StPulse) begin
                        if (width_q != '1) width_q <= width_q + CNT_WIDTH'(1);
                        if (sample > peak_q) peak_q <= sample;
                    end
                end
                StEmit: begin
                    if (handshake) holdoff_q <= holdoff_len;
                end
                StHoldoff: begin
                    if (holdoff_q != '0) holdoff_q <= holdoff_q - CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_gate_controller.sv
// Directed bench for pulse_gate_controller: basic framing, hysteresis,
// backpressure with drops, holdoff, abort/reset, width saturation and range.
module tb_pulse_gate_controller;

    logic        adc_clk;
    logic        rst;
    logic [31:0] adc_dat_a;
    logic [13:0] input_low;
    logic        enable;
    logic [15:0] holdoff_len;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        gate;
    logic        busy;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int gcnt;
    int vcnt;
    int okcnt;

    pulse_gate_controller #(
        .ADC_WIDTH       (14),
        .AXIS_TDATA_WIDTH(32),
        .HYST            (10),
        .CNT_WIDTH       (16)
    ) dut (
        .adc_clk      (adc_clk),
        .rst          (rst),
        .adc_dat_a    (adc_dat_a),
        .input_low    (input_low),
        .enable       (enable),
        .holdoff_len  (holdoff_len),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .gate         (gate),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic feed(input int v);
        adc_dat_a = 32'(v);
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        rst           = 1'b0;
        enable        = 1'b0;
        m_axis_tready = 1'b1;
        input_low     = 14'(-4096);
        holdoff_len   = 16'd0;
        adc_dat_a     = 32'(-5000);
        tick();
        tick();
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_gate", 32'(gate), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_tdata", m_axis_tdata, 32'd0);

        rst    = 1'b1;
        enable = 1'b1;
        feed(-5000);
        feed(-5000);
        chk("armed_gate", 32'(gate), 32'd0);

        // Basic pulse: three samples above threshold
        gcnt = 0;
        feed(-4000); gcnt += 32'(gate);
        feed(-3000); gcnt += 32'(gate);
        feed(-3500); gcnt += 32'(gate);
        chk("basic_busy", 32'(busy), 32'd1);
        feed(-4200); gcnt += 32'(gate);
        chk("basic_gate_cycles", 32'(gcnt), 32'd3);
        chk("basic_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("basic_tdata", m_axis_tdata, 32'h0003_F448);
        feed(-5000);
        chk("basic_accept", 32'(m_axis_tvalid), 32'd0);
        chk("basic_rearm_busy", 32'(busy), 32'd0);

        // Hysteresis band only: no pulse
        gcnt = 0;
        vcnt = 0;
        for (int i = 0; i < 50; i++) begin
            feed((i % 2 == 0) ? -4090 : -4100);
            gcnt += 32'(gate);
            vcnt += 32'(m_axis_tvalid);
        end
        chk("hyst_no_gate", 32'(gcnt), 32'd0);
        chk("hyst_no_event", 32'(vcnt), 32'd0);
        // Start above band, sit inside band, end below
        feed(-4080);
        feed(-4080);
        for (int i = 0; i < 5; i++) feed(-4090);
        chk("hyst_gate_in_band", 32'(gate), 32'd1);
        feed(-4100);
        chk("hyst_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("hyst_tdata", m_axis_tdata, 32'h0007_F010);
        feed(-5000);
        chk("hyst_accept", 32'(m_axis_tvalid), 32'd0);

        // Backpressure: stalled event, second pulse during stall is dropped
        m_axis_tready = 1'b0;
        feed(-4000);
        feed(-3000);
        feed(-4200);
        chk("bp_tdata", m_axis_tdata, 32'h0002_F448);
        okcnt = 0;
        for (int i = 0; i < 20; i++) begin
            feed((i >= 5 && i <= 7) ? -3000 : -4200);
            if (m_axis_tvalid === 1'b1 && m_axis_tdata === 32'h0002_F448) okcnt++;
        end
        chk("bp_stable_cycles", 32'(okcnt), 32'd20);
        chk("bp_drop", 32'(drop_cnt), 32'd1);
        holdoff_len   = 16'd64;
        m_axis_tready = 1'b1;
        feed(-4200);
        chk("bp_one_beat", 32'(m_axis_tvalid), 32'd0);
        chk("holdoff_busy", 32'(busy), 32'd1);

        // Holdoff: pulse at +30 dropped, pulse at +70 emitted
        gcnt = 0;
        for (int i = 1; i <= 73; i++) begin
            feed(((i >= 30 && i <= 32) || (i >= 70 && i <= 72)) ? -3000 : -4200);
            gcnt += 32'(gate);
        end
        chk("holdoff_gate_cycles", 32'(gcnt), 32'd3);
        chk("holdoff_drop", 32'(drop_cnt), 32'd2);
        chk("holdoff_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("holdoff_tdata", m_axis_tdata, 32'h0003_F448);

        // Zero holdoff: armed immediately after the handshake
        holdoff_len = 16'd0;
        feed(-4200);
        chk("h0_busy", 32'(busy), 32'd0);
        feed(-3000);
        chk("h0_gate", 32'(gate), 32'd1);

        // Abort mid-pulse
        feed(-3000);
        enable = 1'b0;
        feed(-3000);
        chk("abort_gate", 32'(gate), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 3; i++) begin
            feed(-4200);
            vcnt += 32'(m_axis_tvalid);
        end
        chk("abort_no_event", 32'(vcnt), 32'd0);
        enable = 1'b1;
        feed(-4200);

        // Reset during EMIT
        m_axis_tready = 1'b0;
        feed(-3000);
        feed(-4200);
        chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("pre_rst_drop", 32'(drop_cnt), 32'd2);
        rst = 1'b0;
        feed(-4200);
        chk("emit_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("emit_rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b1;
        m_axis_tready = 1'b1;
        feed(-4200);

        // Width saturation
        for (int i = 0; i < 70000; i++) feed(-3000);
        chk("sat_gate", 32'(gate), 32'd1);
        feed(-4200);
        chk("sat_tdata", m_axis_tdata, 32'hFFFF_F448);
        feed(-4200);
        chk("sat_accept", 32'(m_axis_tvalid), 32'd0);

        // Upper threshold above full scale: nothing starts (upper bus bits ignored)
        input_low = 14'd8190;
        gcnt = 0;
        for (int i = 0; i < 20; i++) begin
            feed((i % 2 == 0) ? 32'hFFFF_1FFF : 32'h0000_1FFF);
            gcnt += 32'(gate);
        end
        chk("high_no_gate", 32'(gcnt), 32'd0);
        chk("high_busy", 32'(busy), 32'd0);

        // Lowest threshold: no sample can end the pulse
        input_low = 14'(-8192);
        feed(-3000);
        gcnt = 0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            feed(-8192);
            gcnt += 32'(gate);
            vcnt += 32'(m_axis_tvalid);
        end
        chk("low_gate_open", 32'(gcnt), 32'd20);
        chk("low_no_event", 32'(vcnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
